dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the slave end of the CPU's load/store data bus.
- Accepts one read or write request at a time from the processor core (the initiator), with a configurable wait-state latency.
- Replies with an ack pulse, read data and an error flag.
- Lets the core and the top-level bench exercise multi-cycle memory timing instead of an ideal zero-latency array.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
- WAIT, 2, extra wait cycles before the response (0 allowed).
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req  input  1  request strobe; sampled only while idle.
- we  input  1  1 = write (store), 0 = read (load).
- addr  input  32  byte address.
- be  input  4  byte enables; be[i] qualifies wdata[8i+7:8i].
- wdata  input  32  store data.
- pc  input  32  PC of the issuing instruction; used only for trace.
- rdata  output  32  load data; valid while ack=1.
- ack  output  1  one-cycle response pulse.
- err  output  1  error flag; meaningful only while ack=1.
- busy  output  1  high while a transaction is outstanding.

Behaviour:
- Reset (rst=0, async): state IDLE; ack=0, err=0, busy=0, rdata=0. Memory array is not cleared by reset; it is zero-initialised at time 0 only.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1, latch we/addr/be/wdata/pc. This is the accept edge.
  - Go to WAIT with cnt=WAIT, or straight to RESP if WAIT==0.
  - After the accept edge the initiator may change or drop its inputs.
- WAIT: cnt decrements each edge; when cnt reaches 1, the next edge enters RESP.
- RESP:
  - Lasts exactly one cycle: ack=1, busy=1.
  - Next edge returns to IDLE.
  - req is ignored in RESP, so back-to-back requests are spaced WAIT+2 cycles apart.
- Latency: ack is high in the cycle following edge (accept + WAIT).
  - WAIT=2: accept at edge n, ack during cycle after edge n+2.
- busy=1 whenever state != IDLE, including the RESP cycle.
- Error check, evaluated on the latched request:
  - err when addr[1:0] != 0, or when (addr - BASE) >= 4*2**ADDR_W (includes addr < BASE via unsigned wrap).
  - On error: no memory write, rdata=0, ack still issued, err=1.
- Write, no error: committed on the edge entering RESP.
  - Only bytes with be[i]=1 are updated.
  - be=4'h0 gives a normal ack and no change.
- Read, no error: rdata = full word at the index, regardless of be; registered on the edge entering RESP.
- Outside ack:
  - rdata holds its last value.
  - err is 0.
- Reset mid-transaction (WAIT or RESP):
  - Pending request is aborted; no ack.
  - A write not yet committed is discarded.
  - Outputs return to reset values immediately.
- Index = (addr - BASE) >> 2, truncated to ADDR_W bits after the range check.

Optional Feature:
- Macro DM_TRACE_EN.
- When defined: on every committed write with be != 0, print one line via $display in the format "%d@%h: *%h <= %h" with fields $time, latched pc, latched addr, and the resulting merged 32-bit word.
- When undefined:
  - No display code is compiled.
  - pc is accepted but unused.
  - Functional behaviour is identical.

Test Plan:
- WAIT=2, write addr 0x4, wdata 0x12345678, be 4'hF -> ack exactly 3 cycles after accept, err=0. Then read 0x4 -> rdata 0x12345678.
- Write 0x4, be 4'b0010, wdata 0x0000AB00 -> a subsequent read of 0x4 returns 0x1234AB78.
- Read addr 0x6 and read addr 0x1000 (ADDR_W=10) -> both give ack with err=1 and rdata=0. A write to 0x6 leaves word 1 unchanged.
- req held high continuously, WAIT=2 -> one accept every 4 cycles; busy high 3 of every 4 cycles; ack pulses are single-cycle.
- rst pulled low during WAIT of a write to 0x8 -> busy/ack/err drop to 0 at once, ack is never seen, and a later read of 0x8 returns the old value.
- WAIT=0 build, read 0x4 -> ack in the cycle right after the accept edge. With DM_TRACE_EN, a write prints exactly one trace line containing the merged word.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory slave that answers one load/store at a time after WAIT wait states.
// Ports: clk; rst (async, active-low); req/we/addr/be/wdata/pc request inputs;
// rdata/ack/err response outputs; busy while a transaction is outstanding.
// Optional macro DM_TRACE_EN prints one trace line per committed write with be != 0.
module dm_responder #(
  parameter int          ADDR_W = 10,
  parameter int          WAIT   = 2,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int          CW  = $clog2(WAIT + 2);
  localparam logic [32:0] LIM = 33'd1 << (ADDR_W + 2);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic l_we, err_q, idle, accept, enter, c_we, c_err;
  logic [3:0] l_be, c_be;
  logic [31:0] l_addr, l_wdata, c_addr, c_wdata, off, merged;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [2**ADDR_W] = '{default: '0};
  assign idle   = state == S_IDLE;
  assign accept = idle & req;
  assign enter  = rst && state_n == S_RESP;
  // With WAIT == 0 the response is entered on the accept edge itself, so the
  // live inputs stand in for the not-yet-latched request.
  assign c_we    = idle ? we : l_we;
  assign c_addr  = idle ? addr : l_addr;
  assign c_be    = idle ? be : l_be;
  assign c_wdata = idle ? wdata : l_wdata;
  assign off     = c_addr - BASE;
  assign c_err   = c_addr[1:0] != 2'b00 || {1'b0, off} >= LIM;
  assign idx     = off[ADDR_W+1:2];
  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged[8*i+:8] = c_be[i] ? c_wdata[8*i+:8] : mem[idx][8*i+:8];
  end
  assign ack  = state == S_RESP;
  assign busy = !idle;
  assign err  = ack & err_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (accept) begin
      state_n = WAIT == 0 ? S_RESP : S_WAIT;
      cnt_n   = CW'(WAIT);
    end else if (state == S_WAIT) begin
      state_n = cnt == CW'(1) ? S_RESP : S_WAIT;
      cnt_n   = cnt - 1'b1;
    end else if (state == S_RESP) begin
      state_n = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_be    <= '0;
      l_wdata <= '0;
      rdata   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        l_we    <= we;
        l_addr  <= addr;
        l_be    <= be;
        l_wdata <= wdata;
      end
      if (enter) begin
        err_q <= c_err;
        rdata <= c_err ? 32'h0 : c_we ? rdata : mem[idx];
      end
    end
  end
`ifdef DM_TRACE_EN
  logic [31:0] l_pc, c_pc;
  assign c_pc = idle ? pc : l_pc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) l_pc <= '0;
    else if (accept) l_pc <= pc;
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
  // Memory has no reset; a write commits only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter && c_we && !c_err) begin
      mem[idx] <= merged;
`ifdef DM_TRACE_EN
      if (c_be != 4'h0) $display("%d@%h: *%h <= %h", $time, c_pc, c_addr, merged);
`endif
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: table-driven, scoreboarded bench for dm_responder (WAIT=2 and WAIT=0 instances).
module tb_dm_responder;
  localparam int WAIT = 2;
  logic clk = 1'b0, rst = 1'b0, req = 1'b0, req1 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;
  logic [3:0] be = '0;
  logic [31:0] rdata0, rdata1;
  logic ack0, err0, busy0, ack1, err1, busy1;
  int tests = 0, fails = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  vec_t tbl[15];
  exp_t sb[$];

  dm_responder #(.ADDR_W(10), .WAIT(WAIT), .BASE(32'h0)) u0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata), .pc(pc),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));
  dm_responder #(.ADDR_W(10), .WAIT(0), .BASE(32'h0)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .be(be), .wdata(wdata), .pc(pc),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic scramble();
    we    = 1'($urandom);
    addr  = $urandom;
    be    = 4'($urandom);
    wdata = $urandom;
  endtask

  task automatic run(input vec_t t);
    exp_t e;
    int n;
    @(negedge clk);
    req = 1'b1; we = t.we; addr = t.addr; be = t.be; wdata = t.wdata; pc = $urandom;
    e.rd = !t.we; e.rdata = t.rdata; e.err = t.err;
    sb.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
    scramble();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ack0) check("busy_wait", 32'(busy0), 32'd1);
    end while (!ack0 && n < 20);
    check("latency", n, WAIT + 1);
    e = sb.pop_front();
    check("err", 32'(err0), 32'(e.err));
    if (e.rd) check("rdata", rdata0, e.rdata);
    check("busy_resp", 32'(busy0), 32'd1);
    @(negedge clk);
    check("ack_pulse", 32'(ack0), 32'd0);
    check("err_low", 32'(err0), 32'd0);
    check("busy_idle", 32'(busy0), 32'd0);
  endtask

  initial begin
    int acks, busys, seen;
    logic prev;
    tbl[0]  = '{1'b1, 32'h4,    4'hF,    32'h12345678, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h4,    4'h0,    32'h0,        32'h12345678, 1'b0};
    tbl[2]  = '{1'b1, 32'h4,    4'b0010, 32'h0000AB00, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h4,    4'h3,    32'h0,        32'h1234AB78, 1'b0};
    tbl[4]  = '{1'b0, 32'h6,    4'hF,    32'h0,        32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h1000, 4'hF,    32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h6,    4'hF,    32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h4,    4'hF,    32'h0,        32'h1234AB78, 1'b0};
    tbl[8]  = '{1'b1, 32'h8,    4'h0,    32'hDEADBEEF, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 32'h8,    4'hF,    32'h0,        32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h8,    4'hF,    32'hCAFEF00D, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h8,    4'hF,    32'h0,        32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b1, 32'hFFC,  4'b1100, 32'hAABBCCDD, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 32'hFFC,  4'hF,    32'h0,        32'hAABB0000, 1'b0};
    tbl[14] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,       32'h0,        1'b1};

    #1;
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_busy1", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run(tbl[i]);

    // Continuous request: one accept every WAIT+2 cycles.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
    acks = 0; busys = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        check("stream_single", 32'(prev), 32'd0);
        check("stream_rdata", rdata0, 32'h1234AB78);
      end
      if (busy0) busys++;
      prev = ack0;
    end
    req = 1'b0;
    check("stream_acks", acks, 3);
    check("stream_busy", busys, 9);

    // Reset during WAIT of a write to 0x8 aborts and discards it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; be = 4'hF; wdata = 32'h11111111;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", 32'(busy0), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_ack", 32'(ack0), 32'd0);
    check("abort_err", 32'(err0), 32'd0);
    check("abort_rdata", rdata0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0) seen++;
    end
    check("abort_no_ack", seen, 0);
    run('{1'b0, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0});

    // WAIT=0 instance: ack in the cycle right after the accept edge.
    @(negedge clk);
    req1 = 1'b1; we = 1'b1; addr = 32'h4; be = 4'hF; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req1 = 1'b0;
    scramble();
    @(negedge clk);
    check("w0_wr_ack", 32'(ack1), 32'd1);
    check("w0_wr_err", 32'(err1), 32'd0);
    check("w0_wr_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    check("w0_wr_drop", 32'(ack1), 32'd0);
    req1 = 1'b1; we = 1'b0; addr = 32'h4; be = 4'h0;
    @(posedge clk);
    #1 req1 = 1'b0;
    scramble();
    @(negedge clk);
    check("w0_rd_ack", 32'(ack1), 32'd1);
    check("w0_rd_data", rdata1, 32'hA5A5A5A5);
    @(negedge clk);
    check("w0_rd_drop", 32'(ack1), 32'd0);
    check("w0_rd_hold", rdata1, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
